shiftreg_stream: RTL and testbench

Parametrised parallel-in serial-out shift register with valid/ready handshakes on both sides. It loads nwords words of nbits in parallel and emits them nout words per beat, lowest index first. Words shifted out are either recirculated or zero-filled. It feeds serial datapath consumers (adder trees, field arithmetic pipelines) that apply backpressure, and supports back-to-back loads with no bubble.

---
 rtl/shiftreg_pkg.sv | 18 +
 rtl/shiftreg_stream_ctl.sv | 53 +++++
 rtl/shiftreg_stream.sv | 76 +++++++
 tb/tb_shiftreg_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared helpers for the parallel-in / serial-out stream shifter.
// Beat count, counter width and the EMPTY/STREAM encoding.
package shiftreg_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } mode_t;

  function automatic int nbeats(int nw, int no);
    return (no < 1) ? 1 : nw / no;
  endfunction

  function automatic int cnt_width(int nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/shiftreg_stream_ctl.sv
// Beat counter and handshake control for shiftreg_stream.
// Resolves flush > load > pop > hold into load_en / shift_en.
module shiftreg_stream_ctl #(
  parameter int NBEATS = 8,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] remaining,
  output logic          load_en,
  output logic          shift_en
);
  import shiftreg_pkg::*;

  logic [CW-1:0] rem_q;
  logic [CW-1:0] rem_d;
  mode_t         mode;
  logic          pop;

  always_ff @(posedge clk) begin
    if (!rstb) rem_q <= '0;
    else       rem_q <= rem_d;
  end

  always_comb begin
    rem_d = rem_q;
    unique case (1'b1)
      flush:    rem_d = '0;
      load_en:  rem_d = CW'(NBEATS);
      shift_en: rem_d = rem_q - CW'(1);
      default:  rem_d = rem_q;
    endcase
  end

  // load_en and shift_en already exclude flush and each other
  always_comb begin
    mode      = (rem_q != '0) ? STREAM : EMPTY;
    out_valid = (mode == STREAM);
    out_last  = (rem_q == CW'(1));
    remaining = rem_q;
    pop       = out_valid && out_ready;
    in_ready  = ((mode == EMPTY) || (pop && out_last)) && !flush;
    load_en   = in_valid && in_ready;
    shift_en  = pop && !flush && !load_en;
  end

endmodule

// File: rtl/shiftreg_stream.sv
// Parallel-load shift register streaming nout words per beat.
// Shifted-out words recirculate (rotate=1) or zero-fill the top.
module shiftreg_stream
  import shiftreg_pkg::*;
#(
  parameter int nbits  = 8,
  parameter int nwords = 8,
  parameter int nout   = 1,
  parameter int rotate = 0,
  localparam int NBEATS = nbeats(nwords, nout),
  localparam int CW     = cnt_width(NBEATS)
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [nwords-1:0][nbits-1:0]  d,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [nout-1:0][nbits-1:0]    q,
  output logic                          out_last,
  output logic [CW-1:0]                 remaining,
  output logic [nwords-1:0][nbits-1:0]  q_all
);

  localparam int NO_SAFE = (nout < 1) ? 1 : nout;

  generate
    if (nwords < 2 || nout < 1 || (nwords % NO_SAFE) != 0) begin : g_bad
      shiftreg_stream_bad_params u_bad ();
    end
  endgenerate

  logic [nwords-1:0][nbits-1:0] data_q;
  logic [nwords-1:0][nbits-1:0] shifted;
  logic                         load_en;
  logic                         shift_en;

  shiftreg_stream_ctl #(
    .NBEATS (NBEATS),
    .CW     (CW)
  ) u_ctl (
    .clk       (clk),
    .rstb      (rstb),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .remaining (remaining),
    .load_en   (load_en),
    .shift_en  (shift_en)
  );

  for (genvar i = 0; i < nwords; i++) begin : g_sh
    if (i < nwords - nout) begin : g_mv
      assign shifted[i] = data_q[i+nout];
    end else if (rotate != 0) begin : g_rot
      assign shifted[i] = data_q[i-(nwords-nout)];
    end else begin : g_zero
      assign shifted[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb)         data_q <= '0;
    else if (load_en)  data_q <= d;
    else if (shift_en) data_q <= shifted;
  end

  assign q     = data_q[nout-1:0];
  assign q_all = data_q;

endmodule

// File: tb/tb_shiftreg_stream.sv
// Scoreboard bench: two configurations driven side by side,
// expected beats queued at load time and popped by a monitor.
module tb_shiftreg_stream;

  typedef struct {
    logic [47:0] q;
    logic        last;
    int          rem;
  } exp_t;

  int NW [2] = '{4, 6};
  int NO [2] = '{1, 2};
  int ROT[2] = '{0, 1};

  logic clk = 1'b0;
  logic rstb;
  logic iv[2], fl[2], ordy[2];
  logic [31:0] d_a;
  logic [47:0] d_b;

  logic ir_a, ov_a, ol_a, ir_b, ov_b, ol_b;
  logic [7:0]  q_a;
  logic [15:0] q_b;
  logic [2:0]  rem_a;
  logic [1:0]  rem_b;
  logic [31:0] qall_a;
  logic [47:0] qall_b;

  logic        o_ir[2], o_ov[2], o_ol[2];
  logic [47:0] o_q[2], o_qall[2];
  logic [7:0]  o_rem[2];

  logic        s_rst;
  logic        s_iv[2], s_fl[2], s_or[2];
  logic [47:0] s_d[2];

  exp_t        sb[2][$];
  int          mrem[2];
  logic        known[2];
  logic [47:0] qexp[2], loaded[2];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  shiftreg_stream #(.nbits(8), .nwords(4), .nout(1), .rotate(0)) u_a (
    .clk(clk), .rstb(rstb), .in_valid(iv[0]), .in_ready(ir_a),
    .d(d_a), .flush(fl[0]), .out_valid(ov_a), .out_ready(ordy[0]),
    .q(q_a), .out_last(ol_a), .remaining(rem_a), .q_all(qall_a)
  );

  shiftreg_stream #(.nbits(8), .nwords(6), .nout(2), .rotate(1)) u_b (
    .clk(clk), .rstb(rstb), .in_valid(iv[1]), .in_ready(ir_b),
    .d(d_b), .flush(fl[1]), .out_valid(ov_b), .out_ready(ordy[1]),
    .q(q_b), .out_last(ol_b), .remaining(rem_b), .q_all(qall_b)
  );

  assign o_ir[0] = ir_a;  assign o_ir[1] = ir_b;
  assign o_ov[0] = ov_a;  assign o_ov[1] = ov_b;
  assign o_ol[0] = ol_a;  assign o_ol[1] = ol_b;
  assign o_q[0]  = 48'(q_a);
  assign o_q[1]  = 48'(q_b);
  assign o_rem[0] = 8'(rem_a);
  assign o_rem[1] = 8'(rem_b);
  assign o_qall[0] = 48'(qall_a);
  assign o_qall[1] = qall_b;

  task automatic chk(string nm, int id, logic [47:0] act, logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, id, $time, act, exp);
    end
  endtask

  // Monitor: a beat is consumed when valid && ready at the coming edge
  always @(negedge clk) begin
    if (rstb === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (!fl[i] && o_ov[i] && ordy[i]) begin
          exp_t e;
          if (sb[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat dut%0d: got %h want none", i, o_q[i]);
          end else begin
            e = sb[i].pop_front();
            chk("q", i, o_q[i], e.q);
            chk("out_last", i, 48'(o_ol[i]), 48'(e.last));
            chk("remaining", i, 48'(o_rem[i]), 48'(e.rem));
          end
        end
      end
    end
  end

  task automatic idle();
    s_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_iv[i] = 1'b0; s_fl[i] = 1'b0; s_or[i] = 1'b1; s_d[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rstb = s_rst;
    for (int i = 0; i < 2; i++) begin
      iv[i] = s_iv[i]; fl[i] = s_fl[i]; ordy[i] = s_or[i];
    end
    d_a = s_d[0][31:0];
    d_b = s_d[1];
    #1;
    for (int i = 0; i < 2; i++) begin
      int nb;
      logic eir;
      logic [47:0] mask;
      nb = NW[i] / NO[i];
      mask = (48'(1) << (NW[i] * 8)) - 48'(1);
      if (!s_rst) begin
        sb[i].delete();
        mrem[i] = 0; known[i] = 1'b1; qexp[i] = '0;
        continue;
      end
      eir = (mrem[i] == 0 || (mrem[i] == 1 && s_or[i])) && !s_fl[i];
      chk("in_ready", i, 48'(o_ir[i]), 48'(eir));
      chk("out_valid", i, 48'(o_ov[i]), 48'(mrem[i] != 0));
      if (mrem[i] == 0) begin
        chk("out_last_idle", i, 48'(o_ol[i]), 48'(0));
        if (known[i]) chk("q_all", i, o_qall[i], qexp[i]);
      end
      if (s_fl[i]) begin
        sb[i].delete();
        if (mrem[i] != 0) known[i] = 1'b0;
        mrem[i] = 0;
      end else if (s_iv[i] && eir) begin
        for (int k = 0; k < nb; k++) begin
          exp_t e;
          e.q = '0;
          for (int j = 0; j < NO[i]; j++)
            e.q[j*8 +: 8] = s_d[i][(k*NO[i]+j)*8 +: 8];
          e.last = (k == nb - 1);
          e.rem  = nb - k;
          sb[i].push_back(e);
        end
        mrem[i] = nb;
        loaded[i] = s_d[i] & mask;
        known[i] = 1'b0;
      end else if (mrem[i] > 0 && s_or[i]) begin
        mrem[i]--;
        if (mrem[i] == 0) begin
          known[i] = 1'b1;
          qexp[i] = (ROT[i] != 0) ? loaded[i] : '0;
        end
      end
    end
  endtask

  task automatic load_both(logic [47:0] da, logic [47:0] db);
    s_iv[0] = 1'b1; s_d[0] = da;
    s_iv[1] = 1'b1; s_d[1] = db;
    step();
    s_iv[0] = 1'b0; s_iv[1] = 1'b0;
  endtask

  initial begin
    bit [1:0] pat[6] = '{1, 0, 0, 1, 1, 1};
    rstb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; fl[i] = 0; ordy[i] = 0;
      mrem[i] = 0; known[i] = 1; qexp[i] = '0; loaded[i] = '0;
    end
    d_a = '0; d_b = '0;
    idle();
    s_rst = 1'b0;
    repeat (2) step();
    idle();
    step();

    load_both(48'h44332211, 48'h605040302010);
    repeat (6) step();

    load_both(48'h44332211, 48'h605040302010);
    for (int c = 0; c < 6; c++) begin
      s_or[0] = pat[c][0];
      s_or[1] = pat[c][0];
      step();
    end
    idle();
    repeat (3) step();

    s_iv[0] = 1'b1; s_d[0] = 48'h04030201;
    step();
    s_d[0] = 48'hA4A3A2A1;
    repeat (4) step();
    s_iv[0] = 1'b0;
    repeat (6) step();

    load_both(48'h0d0c0b0a, 48'h0f0e0d0c0b0a);
    step();
    s_fl[0] = 1'b1; s_iv[0] = 1'b1; s_d[0] = 48'h99999999;
    s_fl[1] = 1'b1; s_iv[1] = 1'b1; s_d[1] = 48'h999999999999;
    step();
    idle();
    repeat (2) step();

    load_both(48'h87654321, 48'hcafef00dbeef);
    step();
    s_rst = 1'b0;
    step();
    idle();
    step();
    load_both(48'h5a6b7c8d, 48'h112233445566);
    repeat (5) step();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_iv[i] = ($urandom_range(0, 2) != 0);
        s_d[i]  = 48'({$urandom, $urandom});
        s_or[i] = ($urandom_range(0, 3) != 0);
        s_fl[i] = ($urandom_range(0, 24) == 0);
      end
      s_rst = ($urandom_range(0, 99) != 0);
      step();
    end

    idle();
    for (int c = 0; c < 20 && (sb[0].size() + sb[1].size()) != 0; c++)
      step();
    step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (sb[i].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: got %0d beats pending want 0", i, sb[i].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
